if_fetch_unit: RTL and testbench

Instruction fetch stage that produces the PC+4 / instruction pair consumed by the IF/ID pipeline register. It owns the fetch PC, issues one-at-a-time requests to instruction memory through a req/ack handshake, and buffers returned words in a 2-entry queue. It accepts backpressure (`stall`) and control-flow redirects (`redirect`) from the ID stage. When empty it emits a bubble (`im_out` = 0, the MIPS nop).

---
 rtl/if_fetch_unit.sv | 131 +++++++++++++
 tb/tb_if_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one request at a time to
// instruction memory, and queues returned words in a 2-entry FIFO for ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        fetch_valid,
  output logic [31:0] pc_add_out,
  output logic [31:0] im_out
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [31:0] fetch_pc_r;
  logic [31:0] req_pc_r;
  logic [1:0]  count_r;
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [31:0] pc_q_r [2];
  logic [31:0] ins_q_r [2];

  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [2:0]  occ_s;

  // Handshake qualifiers and FSM next state; an issue must leave room for its reply.
  always_comb begin
    pop_s        = fetch_valid & ~stall;
    push_s       = (state_r == ST_WAIT) & im_ack & ~redirect;
    occ_s        = {1'b0, count_r} + {2'b00, push_s} - {2'b00, pop_s};
    issue_s      = ~reset & ~redirect & (occ_s < 3'd2) &
                   ((state_r == ST_RUN) | ((state_r == ST_WAIT) & im_ack));
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (redirect) begin
          state_next_s = ST_RUN;
        end else if (issue_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          state_next_s = im_ack ? ST_RUN : ST_DISCARD;
        end else if (im_ack) begin
          state_next_s = issue_s ? ST_WAIT : ST_RUN;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DISCARD: begin
        if (im_ack) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DISCARD;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // Head of the queue is presented directly; an empty queue shows a nop bubble.
  always_comb begin
    fetch_valid = (count_r != 2'd0);
    im_req      = issue_s;
    im_addr     = fetch_pc_r;
    if (fetch_valid) begin
      pc_add_out = pc_q_r[rd_ptr_r];
      im_out     = ins_q_r[rd_ptr_r];
    end else begin
      pc_add_out = 32'h0000_0000;
      im_out     = 32'h0000_0000;
    end
  end

  // Fetch PC, outstanding address, FIFO and FSM state; redirect flushes everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_RUN;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 32'h0000_0000;
      count_r    <= 2'd0;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      pc_q_r[0]  <= 32'h0000_0000;
      pc_q_r[1]  <= 32'h0000_0000;
      ins_q_r[0] <= 32'h0000_0000;
      ins_q_r[1] <= 32'h0000_0000;
    end else begin
      state_r <= state_next_s;
      if (redirect) begin
        count_r    <= 2'd0;
        rd_ptr_r   <= 1'b0;
        wr_ptr_r   <= 1'b0;
        fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (push_s) begin
          pc_q_r[wr_ptr_r]  <= req_pc_r + 32'd4;
          ins_q_r[wr_ptr_r] <= im_rdata;
          wr_ptr_r          <= ~wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= ~rd_ptr_r;
        end
        count_r <= occ_s[1:0];
        if (issue_s) begin
          req_pc_r   <= fetch_pc_r;
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a small latency-programmable memory answers
// the main instance; a second instance checks the RESET_PC wrap-around case.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata = 32'h0;
  logic        fetch_valid;
  logic [31:0] pc_add_out;
  logic [31:0] im_out;

  logic        im_req2;
  logic [31:0] im_addr2;
  logic        im_ack2 = 1'b0;
  logic [31:0] im_rdata2 = 32'h0;
  logic        fetch_valid2;
  logic [31:0] pc_add_out2;
  logic [31:0] im_out2;

  int          n_vec = 0;
  int          n_err = 0;

  logic        pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  int          pcnt = 0;
  int          lat = 1;

  always #5 clock = ~clock;

  if_fetch_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata), .fetch_valid(fetch_valid),
    .pc_add_out(pc_add_out), .im_out(im_out)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_req(im_req2), .im_addr(im_addr2),
    .im_ack(im_ack2), .im_rdata(im_rdata2), .fetch_valid(fetch_valid2),
    .pc_add_out(pc_add_out2), .im_out(im_out2)
  );

  task automatic capture_req();
    if (im_req === 1'b1 && !pend) begin
      pend  = 1'b1;
      paddr = im_addr;
      pcnt  = lat;
    end
  endtask

  // One clock cycle: memory reply first, then control inputs, then settle.
  task automatic tick(input logic s, input logic r, input logic [31:0] rp);
    @(posedge clock);
    #1;
    if (pend && pcnt == 1) begin
      im_ack   = 1'b1;
      im_rdata = 32'hA500_0000 | paddr;
      pend     = 1'b0;
    end else begin
      im_ack   = 1'b0;
      im_rdata = 32'h0;
      if (pend) pcnt--;
    end
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    #1;
    capture_req();
  endtask

  task automatic apply_reset(input int latency);
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    im_ack = 1'b0; im_rdata = 32'h0; im_ack2 = 1'b0; im_rdata2 = 32'h0;
    pend = 1'b0; lat = latency;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    capture_req();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
    n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", im_req); end
    n_vec++; if (pc_add_out !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", pc_add_out); end
    n_vec++; if (im_out !== 32'h0) begin n_err++; $display("FAIL reset_im: got %h want 0", im_out); end
    n_vec++; if (im_req2 !== 1'b0) begin n_err++; $display("FAIL reset_req2: got %b want 0", im_req2); end
  endtask

  task automatic test_stream();
    apply_reset(1);
    n_vec++; if (im_req !== 1'b1 || im_addr !== 32'h0) begin n_err++; $display("FAIL stream_c0: req %b addr %h want 1 0", im_req, im_addr); end
    n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL stream_c0_valid: got %b want 0", fetch_valid); end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (im_req !== 1'b1 || im_addr !== 32'h4 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1: req %b addr %h valid %b want 1 4 0", im_req, im_addr, fetch_valid); end
    for (int k = 2; k <= 5; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_vec++;
      if (fetch_valid !== 1'b1 || pc_add_out !== 32'(4*(k-1)) || im_out !== (32'hA500_0000 | 32'(4*(k-2))) || im_addr !== 32'(4*k) || im_req !== 1'b1) begin
        n_err++; $display("FAIL stream_c%0d: valid %b pc %h im %h addr %h req %b", k, fetch_valid, pc_add_out, im_out, im_addr, im_req);
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 6; k <= 9; k++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_vec++;
      if (im_req !== 1'b0 || fetch_valid !== 1'b1 || pc_add_out !== 32'h14 || im_out !== 32'hA500_0010) begin
        n_err++; $display("FAIL stall_c%0d: req %b valid %b pc %h im %h want 0 1 14 a5000010", k, im_req, fetch_valid, pc_add_out, im_out);
      end
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (pc_add_out !== 32'h14 || im_req !== 1'b1 || im_addr !== 32'h18) begin n_err++; $display("FAIL stall_rel0: pc %h req %b addr %h want 14 1 18", pc_add_out, im_req, im_addr); end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (pc_add_out !== 32'h18 || im_out !== 32'hA500_0014 || im_addr !== 32'h1C) begin n_err++; $display("FAIL stall_rel1: pc %h im %h addr %h want 18 a5000014 1c", pc_add_out, im_out, im_addr); end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (pc_add_out !== 32'h1C || im_out !== 32'hA500_0018 || im_addr !== 32'h20) begin n_err++; $display("FAIL stall_rel2: pc %h im %h addr %h want 1c a5000018 20", pc_add_out, im_out, im_addr); end
  endtask

  task automatic test_redirect_wait();
    apply_reset(3);
    tick(1'b0, 1'b1, 32'h0000_0100);
    n_vec++; if (im_req !== 1'b0) begin n_err++; $display("FAIL redir_wait_c1_req: got %b want 0", im_req); end
    for (int k = 2; k <= 3; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_vec++; if (im_req !== 1'b0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL redir_discard_c%0d: req %b valid %b want 0 0", k, im_req, fetch_valid); end
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (im_req !== 1'b1 || im_addr !== 32'h100) begin n_err++; $display("FAIL redir_target: req %b addr %h want 1 100", im_req, im_addr); end
    for (int k = 5; k <= 7; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      n_vec++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL redir_empty_c%0d: valid %b want 0", k, fetch_valid); end
    end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || pc_add_out !== 32'h104 || im_out !== 32'hA500_0100) begin n_err++; $display("FAIL redir_first: valid %b pc %h im %h want 1 104 a5000100", fetch_valid, pc_add_out, im_out); end
  endtask

  task automatic test_redirect_ack();
    apply_reset(1);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_0203);
    n_vec++; if (im_ack !== 1'b1 || im_req !== 1'b0) begin n_err++; $display("FAIL redir_ack_c3: ack %b req %b want 1 0", im_ack, im_req); end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h200) begin n_err++; $display("FAIL redir_ack_c4: valid %b req %b addr %h want 0 1 200", fetch_valid, im_req, im_addr); end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b0 || im_addr !== 32'h204) begin n_err++; $display("FAIL redir_ack_c5: valid %b addr %h want 0 204", fetch_valid, im_addr); end
    tick(1'b0, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || pc_add_out !== 32'h204 || im_out !== 32'hA500_0200) begin n_err++; $display("FAIL redir_ack_c6: valid %b pc %h im %h want 1 204 a5000200", fetch_valid, pc_add_out, im_out); end
  endtask

  task automatic test_wrap();
    apply_reset(1);
    n_vec++; if (im_req2 !== 1'b1 || im_addr2 !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_c0: req %b addr %h want 1 fffffffc", im_req2, im_addr2); end
    tick(1'b0, 1'b0, 32'h0);
    im_ack2 = 1'b1; im_rdata2 = 32'h1234_5678;
    #1;
    n_vec++; if (im_req2 !== 1'b1 || im_addr2 !== 32'h0) begin n_err++; $display("FAIL wrap_c1: req %b addr %h want 1 0", im_req2, im_addr2); end
    tick(1'b0, 1'b0, 32'h0);
    im_ack2 = 1'b0; im_rdata2 = 32'h0;
    #1;
    n_vec++; if (fetch_valid2 !== 1'b1 || pc_add_out2 !== 32'h0 || im_out2 !== 32'h1234_5678) begin n_err++; $display("FAIL wrap_c2: valid %b pc %h im %h want 1 0 12345678", fetch_valid2, pc_add_out2, im_out2); end
  endtask

  task automatic test_async_reset();
    apply_reset(1);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    n_vec++; if (fetch_valid !== 1'b1 || pc_add_out !== 32'h4 || im_req !== 1'b0) begin n_err++; $display("FAIL arst_full: valid %b pc %h req %b want 1 4 0", fetch_valid, pc_add_out, im_req); end
    reset = 1'b1;
    #1;
    n_vec++; if (fetch_valid !== 1'b0 || pc_add_out !== 32'h0 || im_out !== 32'h0 || im_req !== 1'b0) begin n_err++; $display("FAIL arst_mid: valid %b pc %h im %h req %b want all 0", fetch_valid, pc_add_out, im_out, im_req); end
    apply_reset(1);
    n_vec++; if (im_req !== 1'b1 || im_addr !== 32'h0 || fetch_valid !== 1'b0) begin n_err++; $display("FAIL arst_restart: req %b addr %h valid %b want 1 0 0", im_req, im_addr, fetch_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
